// File: rtl/execute_muldiv_pkg.sv
// Shared types and op-decoding helpers for the iterative RV64M multiply/divide unit.
package execute_muldiv_pkg;

  typedef enum logic [2:0] {
    MUL    = 3'd0,
    MULH   = 3'd1,
    MULHSU = 3'd2,
    MULHU  = 3'd3,
    DIV    = 3'd4,
    DIVU   = 3'd5,
    REM    = 3'd6,
    REMU   = 3'd7
  } mdu_op_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } mdu_state_t;

  function automatic logic is_div(input mdu_op_t op);
    return op inside {DIV, DIVU, REM, REMU};
  endfunction

  function automatic logic is_signed_a(input mdu_op_t op);
    return op inside {MULH, MULHSU, DIV, REM};
  endfunction

  function automatic logic is_signed_b(input mdu_op_t op);
    return op inside {MULH, DIV, REM};
  endfunction

endpackage

// File: rtl/execute_muldiv_if.sv
// Request/result handshake bundle between the execute stage and the muldiv unit.
interface execute_muldiv_if #(
  parameter int XLEN  = 64,
  parameter int TAG_W = 69
);
  logic                      inValid;
  logic                      inReady;
  execute_muldiv_pkg::mdu_op_t inOp;
  logic                      inWord;
  logic [XLEN-1:0]           inA;
  logic [XLEN-1:0]           inB;
  logic [TAG_W-1:0]          inTag;
  logic                      outValid;
  logic                      outReady;
  logic [XLEN-1:0]           outResult;
  logic [TAG_W-1:0]          outTag;

  modport master (
    output inValid, inOp, inWord, inA, inB, inTag, outReady,
    input  inReady, outValid, outResult, outTag
  );

  modport slave (
    input  inValid, inOp, inWord, inA, inB, inTag, outReady,
    output inReady, outValid, outResult, outTag
  );
endinterface

// File: rtl/execute_muldiv_iter_step.sv
// Combinational iteration slice: BITS_PER_CYCLE shift-add (mul, LSB first) or
// restoring-divide (MSB first) steps over the {hi,lo} working pair.
module mdu_iter_step #(
  parameter int XLEN           = 64,
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic            isDiv,
  input  logic [XLEN-1:0] opnd,
  input  logic [XLEN-1:0] hiIn,
  input  logic [XLEN-1:0] loIn,
  output logic [XLEN-1:0] hiOut,
  output logic [XLEN-1:0] loOut
);
  logic [XLEN-1:0] hiC [BITS_PER_CYCLE+1];
  logic [XLEN-1:0] loC [BITS_PER_CYCLE+1];

  assign hiC[0] = hiIn;
  assign loC[0] = loIn;

  for (genvar i = 0; i < BITS_PER_CYCLE; i++) begin : g_bit
    logic [XLEN:0] sum, add, sh, diff;
    logic          fits;
    // mul: the carry of hi+opnd becomes the new MSB after the right shift
    assign sum  = {1'b0, hiC[i]} + {1'b0, opnd};
    assign add  = loC[i][0] ? sum : {1'b0, hiC[i]};
    // div: partial remainder needs one extra bit before the trial subtract
    assign sh   = {hiC[i], loC[i][XLEN-1]};
    assign diff = sh - {1'b0, opnd};
    assign fits = ~diff[XLEN];
    assign hiC[i+1] = isDiv ? (fits ? diff[XLEN-1:0] : sh[XLEN-1:0]) : add[XLEN:1];
    assign loC[i+1] = isDiv ? {loC[i][XLEN-2:0], fits} : {add[0], loC[i][XLEN-1:1]};
  end

  assign hiOut = hiC[BITS_PER_CYCLE];
  assign loOut = loC[BITS_PER_CYCLE];
endmodule

// File: rtl/execute_muldiv.sv
// Iterative RV64M mul/div unit: IDLE -> BUSY (N/BITS_PER_CYCLE steps) -> DONE.
// Optional MDU_EARLY_OUT_EN: div-by-zero, signed overflow and zero-operand mul go IDLE -> DONE.
module execute_muldiv import execute_muldiv_pkg::*; #(
  parameter int XLEN           = 64,
  parameter int BITS_PER_CYCLE = 1,
  parameter int TAG_W          = 69
) (
  input logic             clk,
  input logic             reset,
  input logic             flush,
  execute_muldiv_if.slave mdu
);
  localparam int CNT_W = $clog2(XLEN / BITS_PER_CYCLE) + 1;

  mdu_state_t       state, stateNxt;
  logic [CNT_W-1:0] cnt;
  mdu_op_t          opQ;
  logic             wordQ, negAQ, negBQ, divZeroQ;
  logic [XLEN-1:0]  hi, lo, opnd, hiNxt, loNxt, resQ, finalRes, earlyRes, quo, rem;
  logic [2*XLEN-1:0] prod;
  logic [TAG_W-1:0] tagQ;
  logic             accept, lastStep, earlyOut, zB;
  logic [XLEN:0]    absA, absB;

  function automatic logic [XLEN-1:0] sext32(input logic [31:0] x);
    return XLEN'($signed(x));
  endfunction

  // {negative, magnitude} in the N-bit domain selected by word
  function automatic logic [XLEN:0] absOf(input logic [XLEN-1:0] x, input logic word,
                                          input logic sgn);
    logic [31:0]     n32;
    logic [XLEN-1:0] v;
    logic            n;
    n32 = -x[31:0];
    n   = sgn & (word ? x[31] : x[XLEN-1]);
    v   = word ? XLEN'(x[31:0]) : x;
    if (n) v = word ? XLEN'(n32) : -x;
    return {n, v};
  endfunction

  assign absA = absOf(mdu.inA, mdu.inWord, is_signed_a(mdu.inOp));
  assign absB = absOf(mdu.inB, mdu.inWord, is_signed_b(mdu.inOp));
  assign zB   = mdu.inWord ? (mdu.inB[31:0] == 32'd0) : (mdu.inB == '0);

`ifdef MDU_EARLY_OUT_EN
  localparam logic [XLEN-1:0] MIN_X = {1'b1, {(XLEN-1){1'b0}}};
  logic zA, ovf;
  always_comb begin
    zA  = mdu.inWord ? (mdu.inA[31:0] == 32'd0) : (mdu.inA == '0);
    ovf = is_signed_a(mdu.inOp) &&
          (mdu.inWord ? (mdu.inA[31:0] == 32'h8000_0000 && mdu.inB[31:0] == 32'hFFFF_FFFF)
                      : (mdu.inA == MIN_X && mdu.inB == '1));
    earlyOut = is_div(mdu.inOp) ? (zB || ovf) : (zA || zB);
    earlyRes = '0;
    if (mdu.inOp inside {DIV, DIVU})
      earlyRes = zB ? '1 : (mdu.inWord ? sext32(32'h8000_0000) : MIN_X);
    else if (mdu.inOp inside {REM, REMU} && zB)
      earlyRes = mdu.inWord ? sext32(mdu.inA[31:0]) : mdu.inA;
  end
`else
  assign earlyOut = 1'b0;
  assign earlyRes = '0;
`endif

  mdu_iter_step #(.XLEN(XLEN), .BITS_PER_CYCLE(BITS_PER_CYCLE)) u_step (
    .isDiv(is_div(opQ)), .opnd(opnd), .hiIn(hi), .loIn(lo), .hiOut(hiNxt), .loOut(loNxt)
  );

  // Sign fix and W extension, evaluated on the final step's output
  always_comb begin
    prod = wordQ ? (2*XLEN)'({hiNxt[31:0], loNxt[XLEN-1 -: 32]}) : {hiNxt, loNxt};
    if (negAQ ^ negBQ) prod = -prod;
    quo = (negAQ ^ negBQ) ? -loNxt : loNxt;
    rem = negAQ ? -hiNxt : hiNxt;
    case (opQ)
      MUL:                 finalRes = wordQ ? sext32(prod[31:0]) : prod[XLEN-1:0];
      MULH, MULHSU, MULHU: finalRes = wordQ ? sext32(prod[63:32]) : prod[2*XLEN-1:XLEN];
      DIV, DIVU:           finalRes = divZeroQ ? '1 : (wordQ ? sext32(quo[31:0]) : quo);
      default:             finalRes = wordQ ? sext32(rem[31:0]) : rem;
    endcase
  end

  always_comb begin
    stateNxt = state;
    accept   = 1'b0;
    lastStep = (cnt == CNT_W'(1));
    case (state)
      IDLE: if (mdu.inValid && !flush) begin
        accept   = 1'b1;
        stateNxt = earlyOut ? DONE : BUSY;
      end
      BUSY:    if (lastStep) stateNxt = DONE;
      DONE:    if (mdu.outReady) stateNxt = IDLE;
      default: stateNxt = IDLE;
    endcase
    if (flush) stateNxt = IDLE;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      cnt      <= '0;
      opQ      <= MUL;
      wordQ    <= 1'b0;
      negAQ    <= 1'b0;
      negBQ    <= 1'b0;
      divZeroQ <= 1'b0;
      hi       <= '0;
      lo       <= '0;
      opnd     <= '0;
      resQ     <= '0;
      tagQ     <= '0;
    end else begin
      state <= stateNxt;
      if (accept) begin
        opQ      <= mdu.inOp;
        wordQ    <= mdu.inWord;
        tagQ     <= mdu.inTag;
        negAQ    <= absA[XLEN];
        negBQ    <= absB[XLEN];
        divZeroQ <= zB;
        hi       <= '0;
        cnt      <= mdu.inWord ? CNT_W'(32 / BITS_PER_CYCLE) : CNT_W'(XLEN / BITS_PER_CYCLE);
        // div consumes the dividend MSB-first, so W dividends are left-aligned
        if (is_div(mdu.inOp)) begin
          lo   <= mdu.inWord ? absA[XLEN-1:0] << (XLEN - 32) : absA[XLEN-1:0];
          opnd <= absB[XLEN-1:0];
        end else begin
          lo   <= absB[XLEN-1:0];
          opnd <= absA[XLEN-1:0];
        end
        if (earlyOut) resQ <= earlyRes;
      end else if (state == BUSY && !flush) begin
        hi  <= hiNxt;
        lo  <= loNxt;
        cnt <= cnt - CNT_W'(1);
        if (lastStep) resQ <= finalRes;
      end
    end
  end

  assign mdu.inReady   = (state == IDLE);
  assign mdu.outValid  = (state == DONE);
  assign mdu.outResult = resQ;
  assign mdu.outTag    = tagQ;
endmodule
